// File: rtl/icache_downstream_responder.sv
// Memory-side responder for the icache downstream request/data channel.
// Line-fill requests are queued in order. Each request's line is returned
// a fixed LAT cycles after acceptance at the earliest, and never ahead of an
// older request. The line data is a deterministic function of the line address.
module icache_downstream_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 8,
    parameter int LAT    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    downstream_txreq_vld,
    output logic                    downstream_txreq_rdy,
    input  logic [ADDR_W-1:0]       downstream_txreq_addr,
    input  logic [ID_W-1:0]         downstream_txreq_entry_id,
    output logic                    downstream_rxdat_vld,
    input  logic                    downstream_rxdat_rdy,
    output logic [DATA_W-1:0]       downstream_rxdat_data,
    output logic [ID_W-1:0]         downstream_rxdat_entry_id,
    output logic [$clog2(DEPTH):0]  outstanding
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int EXT_W = (ADDR_W > 32) ? ADDR_W : 32;
    localparam int WORDS = DATA_W / 32;

    // Byte-offset bits within a line; cleared to form the line address.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [IDX_W-1:0]  widx, ridx;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];

    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] line_addr;
    logic [EXT_W-1:0]  head_ext;

    assign widx  = wptr_q[IDX_W-1:0];
    assign ridx  = rptr_q[IDX_W-1:0];
    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) && (widx == ridx);
    assign empty = (wptr_q == rptr_q);

    // Ready depends only on registered pointers, so there is no path from rxdat_rdy.
    assign downstream_txreq_rdy = !full;
    assign push                 = downstream_txreq_vld && !full;

    // The head becomes visible once its countdown has expired. Younger entries wait behind it.
    assign downstream_rxdat_vld      = !empty && (cnt_q[ridx] == '0);
    assign downstream_rxdat_entry_id = id_q[ridx];
    assign pop                       = downstream_rxdat_vld && downstream_rxdat_rdy;

    assign outstanding = wptr_q - rptr_q;
    assign line_addr   = downstream_txreq_addr & ~OFF_MASK;

    // Next pointer values: advance on each accepted push / pop.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);
    end

    // Per-slot countdown: load LAT-1 on push, otherwise decrement and saturate at zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push && (widx == IDX_W'(i))) begin
                cnt_d[i] = CNT_W'(LAT - 1);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Control state: pointers and countdowns, cleared by reset (active high).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Payload storage: written on push, read only while the slot is occupied.
    always_ff @(posedge clk) begin
        // NOTE: payload memory is deliberately not reset; a slot is always written before it can be read.
        if (push) begin
            addr_q[widx] <= line_addr;
            id_q[widx]   <= downstream_txreq_entry_id;
        end
    end

    // Line data: 32-bit word i is the (32-bit) line address plus 4*i.
    always_comb begin
        head_ext = EXT_W'(addr_q[ridx]);
        for (int i = 0; i < WORDS; i++) begin
            downstream_rxdat_data[32*i +: 32] = head_ext[31:0] + 32'(4 * i);
        end
    end

endmodule

// File: doc/icache_downstream_responder.md
# icache_downstream_responder

- Synthesizable downstream responder: the memory side of the icache downstream request/data channel.
- Accepts line-fill requests that the icache issues on `downstream_txreq`.
- Returns one full cache line per request on `downstream_rxdat` after a fixed, programmable latency, in request order. The line data is a deterministic function of the address.
- Sits below the icache in the `toy_pack` test environment. A thin wrapper packs/unpacks `pc_req_t` and `downstream_rxdat_t` around the flat ports below.

## Interface
- `ADDR_W`, 32, request address width.
- `DATA_W`, 256, line width in bits; multiple of 32.
- `ID_W`, `MSHR_ENTRY_INDEX_WIDTH`, MSHR entry id width.
- `DEPTH`, 8, outstanding-request queue depth; power of 2, ≥2.
- `LAT`, 4, request-to-response latency in cycles; ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-high. The name is kept from the `toy_pack` interface naming; the reset is asserted when high.
- `downstream_txreq_vld`  in  1  request valid.
- `downstream_txreq_rdy`  out  1  request ready.
- `downstream_txreq_addr`  in  ADDR_W  request address.
- `downstream_txreq_entry_id`  in  ID_W  MSHR entry id.
- `downstream_rxdat_vld`  out  1  line data valid.
- `downstream_rxdat_rdy`  in  1  line data ready.
- `downstream_rxdat_data`  out  DATA_W  line data.
- `downstream_rxdat_entry_id`  out  ID_W  echoed entry id.
- `outstanding`  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- **Queue structure**
  - Circular FIFO of DEPTH entries; each entry holds {line_addr, entry_id, cnt}.
  - Write/read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - full = pointers differ only in MSB; empty = pointers equal.
- **Push**
  - `downstream_txreq_rdy` = !full. There is no bypass: when full, a same-cycle pop does not free a slot for a same-cycle push.
  - Push when vld&rdy.
  - Stored line_addr = addr with its low $clog2(DATA_W/8) bits cleared.
  - cnt is loaded with LAT-1.
- **Counters**
  - Every cycle, every occupied entry with cnt≠0 decrements by 1; cnt saturates at 0.
  - Unoccupied entries are don't-care.
- **Response**
  - `downstream_rxdat_vld` = !empty && head.cnt==0.
  - Data and entry_id are combinational from the head entry.
  - 32-bit word i of the data (bits 32i+31:32i) = (line_addr + 4·i) truncated to 32 bits. line_addr is zero-extended when ADDR_W<32 and truncated when ADDR_W>32.
  - Pop when vld&rdy.
  - Once vld is asserted, vld, data and entry_id are held stable until the pop.
- **Ordering**
  - Strictly in order. A younger entry whose cnt has reached 0 waits behind the head.
  - Entry ids are opaque and are not checked for uniqueness.
- **Occupancy**
  - `outstanding` = wptr − rptr, with width $clog2(DEPTH)+1.
  - Simultaneous push and pop leaves it unchanged.
- **Reset**
  - Sync reset clears both pointers and all cnt fields.
  - Reset asserted mid-operation drops all in-flight requests with no response.
  - Outputs during and after reset: txreq_rdy=1, rxdat_vld=0, outstanding=0. data/entry_id reflect the stale head and are don't-care while vld=0.

## Timing
- A request accepted at the edge ending cycle t gives rxdat_vld=1 in cycle t+LAT at the earliest.
- That earliest response appears if the queue is empty ahead of the request, or its predecessor has already popped.
- Back-to-back requests in cycles t, t+1, … with rxdat_rdy held at 1 produce responses in cycles t+LAT, t+LAT+1, …; throughput is 1 line/cycle.
- txreq_rdy falls in the cycle after the push that fills the queue.
- txreq_rdy rises in the cycle after the first pop from full.
- No combinational path exists from rxdat_rdy to txreq_rdy, or from txreq_vld to rxdat_vld.

## Test plan
- **Reset values.** Hold rst_n=1 for 3 cycles, then release → txreq_rdy=1, rxdat_vld=0, outstanding=0 in every cycle.
- **Single request, LAT=4.**
  - Stimulus: addr=0x0000_1234, entry_id=3 accepted in cycle 10, rxdat_rdy=1.
  - Response: rxdat_vld is high only in cycle 14, with entry_id=3.
  - Data word0=0x0000_1220, word1=0x0000_1224, …, word7=0x0000_123C.
- **Fill and backpressure, DEPTH=8.**
  - Stimulus: rxdat_rdy=0, 10 consecutive requests (ids 0..9).
  - Response: exactly ids 0..7 are accepted; txreq_rdy=0 from the cycle after the 8th push; outstanding=8.
  - Then raise rxdat_rdy → ids 0..7 are returned in order, one per cycle, then ids 8 and 9, each response no earlier than its own accept cycle + LAT.
- **Hold under stall.** With rdy low for 5 cycles while vld is high → data and entry_id remain bit-identical across all 5 cycles.
- **Random stress.** 1000 requests with random vld and rdy (50% duty), ids cycling mod 2^ID_W → the scoreboard sees in-order ids, the data function matches, and outstanding is always ≤8.
- **Reset mid-flight.** 5 requests accepted, rst_n=1 for 1 cycle before any response → no responses appear, outstanding=0, and a new request is served after LAT cycles.
